mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Memory arbiter: shares one async SRAM port and a UART between instruction fetch
// and data accesses, one transaction at a time, data side having priority.
package mem_arbiter_pkg;
  typedef enum logic [2:0] {
    MEM_W_STORE = 3'd0,
    MEM_B_STORE = 3'd1,
    MEM_W_LOAD  = 3'd2,
    MEM_B_LOAD  = 3'd3,
    MEM_NONE    = 3'd4
  } mem_op_e;
endpackage

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  mem_op_e     dm_op,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        stall,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic [3:0]  ram_be_n,
  output logic [19:0] ram_addr,
  output logic [31:0] ram_dout,
  output logic        ram_dout_en,
  input  logic [31:0] ram_din,
  output logic        uart_tx_start,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_tx_busy,
  input  logic        uart_rx_valid,
  input  logic [7:0]  uart_rx_data,
  output logic        uart_rx_ack
);

  localparam int unsigned CNT_W = $clog2(ACCESS_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 2);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_e;
  typedef enum logic [1:0] {K_SRAM, K_UART_DATA, K_UART_STAT, K_UNMAP} kind_e;

  function automatic kind_e decode(input logic [31:0] a);
    if (a[31:22] == 10'h200)      return K_SRAM;
    else if (a == 32'hBFD0_03F8)  return K_UART_DATA;
    else if (a == 32'hBFD0_03FC)  return K_UART_STAT;
    else                          return K_UNMAP;
  endfunction

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  kind_e             kind_q, kind_d;
  logic              is_if_q, is_if_d;
  logic              store_q, store_d;
  logic              byte_q, byte_d;
  logic [1:0]        lane_q, lane_d;
  logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic [3:0]        be_n_q, be_n_d;
  logic [19:0]       addr_q, addr_d;
  logic [31:0]       dout_q, dout_d;
  logic              dout_en_q, dout_en_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              dm_ready_q, dm_ready_d, if_ready_q, if_ready_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              rx_ack_q, rx_ack_d;

  logic              g_valid, g_if, g_store, g_byte;
  logic [31:0]       g_addr;
  kind_e             g_kind;
  logic [7:0]        lane_byte;

  assign lane_byte = ram_din[{lane_q, 3'b000} +: 8];

  assign stall = (if_req & ~if_ready_q) | ((dm_op != MEM_NONE) & ~dm_ready_q);

  assign if_rdata      = rdata_q;
  assign dm_rdata      = rdata_q;
  assign if_ready      = if_ready_q;
  assign dm_ready      = dm_ready_q;
  assign ram_ce_n      = ce_n_q;
  assign ram_oe_n      = oe_n_q;
  assign ram_we_n      = we_n_q;
  assign ram_be_n      = be_n_q;
  assign ram_addr      = addr_q;
  assign ram_dout      = dout_q;
  assign ram_dout_en   = dout_en_q;
  assign uart_tx_start = tx_start_q;
  assign uart_tx_data  = tx_data_q;
  assign uart_rx_ack   = rx_ack_q;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      kind_q     <= K_UNMAP;
      is_if_q    <= 1'b0;
      store_q    <= 1'b0;
      byte_q     <= 1'b0;
      lane_q     <= 2'b00;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      be_n_q     <= 4'hF;
      addr_q     <= '0;
      dout_q     <= '0;
      dout_en_q  <= 1'b0;
      rdata_q    <= '0;
      dm_ready_q <= 1'b0;
      if_ready_q <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      rx_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      kind_q     <= kind_d;
      is_if_q    <= is_if_d;
      store_q    <= store_d;
      byte_q     <= byte_d;
      lane_q     <= lane_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      be_n_q     <= be_n_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      dout_en_q  <= dout_en_d;
      rdata_q    <= rdata_d;
      dm_ready_q <= dm_ready_d;
      if_ready_q <= if_ready_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      rx_ack_q   <= rx_ack_d;
    end
  end

  // Arbitration, next state and next outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    kind_d     = kind_q;
    is_if_d    = is_if_q;
    store_d    = store_q;
    byte_d     = byte_q;
    lane_d     = lane_q;
    ce_n_d     = 1'b1;
    oe_n_d     = 1'b1;
    we_n_d     = 1'b1;
    be_n_d     = be_n_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    dout_en_d  = 1'b0;
    rdata_d    = rdata_q;
    dm_ready_d = 1'b0;
    if_ready_d = 1'b0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    rx_ack_d   = 1'b0;

    g_valid = 1'b0;
    g_if    = 1'b0;
    g_store = 1'b0;
    g_byte  = 1'b0;
    g_addr  = dm_addr;
    g_kind  = K_UNMAP;

    // A UART store blocked on a busy transmitter holds the port rather than yielding to fetch
    if (dm_op != MEM_NONE) begin
      g_addr  = dm_addr;
      g_kind  = decode(dm_addr);
      g_store = (dm_op == MEM_W_STORE) || (dm_op == MEM_B_STORE);
      g_byte  = (dm_op == MEM_B_STORE) || (dm_op == MEM_B_LOAD);
      g_valid = !((g_kind == K_UART_DATA) && g_store && uart_tx_busy);
    end else if (if_req) begin
      g_if    = 1'b1;
      g_addr  = if_addr;
      g_kind  = (decode(if_addr) == K_SRAM) ? K_SRAM : K_UNMAP;
      g_valid = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (g_valid) begin
          kind_d  = g_kind;
          is_if_d = g_if;
          store_d = g_store;
          byte_d  = g_byte;
          lane_d  = g_addr[1:0];
          case (g_kind)
            K_SRAM: begin
              state_d = S_SETUP;
              ce_n_d  = 1'b0;
              oe_n_d  = g_store;
              addr_d  = g_addr[21:2];
              be_n_d  = g_byte ? ~(4'b0001 << g_addr[1:0]) : 4'b0000;
              dout_d  = g_byte ? {4{dm_wdata[7:0]}} : dm_wdata;
            end
            K_UART_DATA: begin
              if (g_store) begin
                state_d    = S_SETUP;
                tx_start_d = 1'b1;
                tx_data_d  = dm_wdata[7:0];
              end else begin
                state_d    = S_DONE;
                dm_ready_d = 1'b1;
                rdata_d    = uart_rx_valid ? {24'b0, uart_rx_data} : 32'b0;
                rx_ack_d   = uart_rx_valid;
              end
            end
            K_UART_STAT: begin
              state_d    = S_DONE;
              dm_ready_d = 1'b1;
              if (!g_store) rdata_d = {30'b0, uart_rx_valid, ~uart_tx_busy};
            end
            default: begin
              state_d    = S_DONE;
              dm_ready_d = ~g_if;
              if_ready_d = g_if;
              if (!g_store) rdata_d = '0;
            end
          endcase
        end
      end
      S_SETUP: begin
        if (kind_q == K_SRAM) begin
          state_d   = S_ACCESS;
          cnt_d     = '0;
          ce_n_d    = 1'b0;
          oe_n_d    = store_q;
          we_n_d    = ~store_q;
          dout_en_d = store_q;
        end else begin
          state_d    = S_DONE;
          dm_ready_d = 1'b1;
        end
      end
      S_ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          state_d    = S_DONE;
          dm_ready_d = ~is_if_q;
          if_ready_d = is_if_q;
          if (!store_q) rdata_d = byte_q ? {{24{lane_byte[7]}}, lane_byte} : ram_din;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          ce_n_d    = 1'b0;
          oe_n_d    = store_q;
          we_n_d    = ~store_q;
          dout_en_d = store_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table over every address class,
// plus sequences for arbitration, UART back-pressure and reset mid-access.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AC      = 2;
  localparam int LAT_RAM = AC + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr, if_rdata;
  logic        if_ready;
  mem_op_e     dm_op;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_ready, stall;
  logic        ram_ce_n, ram_oe_n, ram_we_n;
  logic [3:0]  ram_be_n;
  logic [19:0] ram_addr;
  logic [31:0] ram_dout, ram_din;
  logic        ram_dout_en;
  logic        uart_tx_start, uart_tx_busy, uart_rx_valid, uart_rx_ack;
  logic [7:0]  uart_tx_data, uart_rx_data;

  always #5 clk = ~clk;

  mem_arbiter #(.ACCESS_CYCLES(AC)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_op(dm_op), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .dm_ready(dm_ready), .stall(stall),
    .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .ram_be_n(ram_be_n),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_dout_en(ram_dout_en), .ram_din(ram_din),
    .uart_tx_start(uart_tx_start), .uart_tx_data(uart_tx_data), .uart_tx_busy(uart_tx_busy),
    .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data), .uart_rx_ack(uart_rx_ack)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        chk_rdata;
    logic        ack;
    int          due;
  } exp_t;

  typedef struct {
    mem_op_e     op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] din;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        busy;
    logic        ram;
    logic [31:0] exp_rdata;
    logic        exp_ack;
    int          lat;
    logic [3:0]  exp_be;
    logic [19:0] exp_addr;
    logic [31:0] exp_dout;
    int          exp_tx;
  } vec_t;

  exp_t dm_q[$];
  exp_t if_q[$];

  int n_chk = 0, n_pass = 0, cyc = 0;
  int ce_cnt, we_cnt, tx_cnt, tx_cyc;
  logic [19:0] seen_addr;
  logic [3:0]  seen_be;
  logic        seen_oe, seen_stall;
  logic [31:0] seen_dout;
  logic [7:0]  seen_tx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic is_st(input mem_op_e op);
    return (op == MEM_W_STORE) || (op == MEM_B_STORE);
  endfunction

  // Observe one cycle at the falling edge; retire scoreboard entries on ready pulses
  task automatic sample();
    exp_t e;
    seen_stall = stall;
    if (ram_ce_n == 1'b0) begin
      ce_cnt++; seen_addr = ram_addr; seen_be = ram_be_n; seen_oe = ram_oe_n;
    end
    if (ram_we_n == 1'b0) begin
      we_cnt++; seen_dout = ram_dout;
      chk("dout_en_with_we", 32'(ram_dout_en), 32'd1);
    end
    if (uart_tx_start == 1'b1) begin
      tx_cnt++; seen_tx = uart_tx_data; tx_cyc = cyc;
    end
    if (dm_ready == 1'b1) begin
      if (dm_q.size() == 0) chk("dm_ready_unexpected", 32'(dm_ready), 32'd0);
      else begin
        e = dm_q.pop_front();
        if (e.chk_rdata) chk("dm_rdata", dm_rdata, e.rdata);
        chk("dm_latency", 32'(cyc), 32'(e.due));
        chk("rx_ack", 32'(uart_rx_ack), 32'(e.ack));
      end
      dm_op = MEM_NONE;
    end else if (uart_rx_ack == 1'b1) chk("rx_ack_stray", 32'(uart_rx_ack), 32'd0);
    if (if_ready == 1'b1) begin
      if (if_q.size() == 0) chk("if_ready_unexpected", 32'(if_ready), 32'd0);
      else begin
        e = if_q.pop_front();
        chk("if_rdata", if_rdata, e.rdata);
        chk("if_latency", 32'(cyc), 32'(e.due));
      end
      if_req = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    sample();
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((dm_q.size() != 0 || if_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    if (dm_q.size() != 0 || if_q.size() != 0) begin
      chk("ready_timeout", 32'(dm_q.size() + if_q.size()), 32'd0);
      dm_q.delete(); if_q.delete();
      dm_op = MEM_NONE; if_req = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    vec_t vecs[14];
    vec_t v;
    exp_t e;
    int   c0;

    //           op           addr          wdata         din           rxv   rxd    busy  ram   exp_rdata     ack   lat      be       addr        dout          tx
    vecs[0]  = '{MEM_W_STORE, 32'h80000010, 32'hDEADBEEF, 32'h0,        1'b0, 8'h00, 1'b0, 1'b1, 32'h0,        1'b0, LAT_RAM, 4'b0000, 20'h00004, 32'hDEADBEEF, 0};
    vecs[1]  = '{MEM_B_LOAD,  32'h80000013, 32'h0,        32'h80FF0000, 1'b0, 8'h00, 1'b0, 1'b1, 32'hFFFFFF80, 1'b0, LAT_RAM, 4'b0111, 20'h00004, 32'h0,        0};
    vecs[2]  = '{MEM_W_LOAD,  32'h803FFFFC, 32'h0,        32'h12345678, 1'b0, 8'h00, 1'b0, 1'b1, 32'h12345678, 1'b0, LAT_RAM, 4'b0000, 20'hFFFFF, 32'h0,        0};
    vecs[3]  = '{MEM_B_STORE, 32'h80000005, 32'h123456A5, 32'h0,        1'b0, 8'h00, 1'b0, 1'b1, 32'h0,        1'b0, LAT_RAM, 4'b1101, 20'h00001, 32'hA5A5A5A5, 0};
    vecs[4]  = '{MEM_B_LOAD,  32'h80000001, 32'h0,        32'hFFFF7F00, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0000007F, 1'b0, LAT_RAM, 4'b1101, 20'h00000, 32'h0,        0};
    vecs[5]  = '{MEM_B_LOAD,  32'h80000000, 32'h0,        32'h000000FE, 1'b0, 8'h00, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, LAT_RAM, 4'b1110, 20'h00000, 32'h0,        0};
    vecs[6]  = '{MEM_W_LOAD,  32'h80400000, 32'h0,        32'hDEADBEEF, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,        1'b0, 1,       4'b0000, 20'h00000, 32'h0,        0};
    vecs[7]  = '{MEM_W_LOAD,  32'hBFD003FC, 32'h0,        32'h0,        1'b1, 8'h00, 1'b0, 1'b0, 32'h00000003, 1'b0, 1,       4'b0000, 20'h00000, 32'h0,        0};
    vecs[8]  = '{MEM_W_LOAD,  32'hBFD003FC, 32'h0,        32'h0,        1'b0, 8'h00, 1'b1, 1'b0, 32'h00000000, 1'b0, 1,       4'b0000, 20'h00000, 32'h0,        0};
    vecs[9]  = '{MEM_B_LOAD,  32'hBFD003F8, 32'h0,        32'h0,        1'b1, 8'h5A, 1'b0, 1'b0, 32'h0000005A, 1'b1, 1,       4'b0000, 20'h00000, 32'h0,        0};
    vecs[10] = '{MEM_W_LOAD,  32'hBFD003F8, 32'h0,        32'h0,        1'b0, 8'h77, 1'b0, 1'b0, 32'h00000000, 1'b0, 1,       4'b0000, 20'h00000, 32'h0,        0};
    vecs[11] = '{MEM_W_LOAD,  32'h00000000, 32'h0,        32'hFFFFFFFF, 1'b0, 8'h00, 1'b0, 1'b0, 32'h00000000, 1'b0, 1,       4'b0000, 20'h00000, 32'h0,        0};
    vecs[12] = '{MEM_W_STORE, 32'hBFD003F8, 32'h000000C3, 32'h0,        1'b0, 8'h00, 1'b0, 1'b0, 32'h0,        1'b0, 2,       4'b0000, 20'h00000, 32'h000000C3, 1};
    vecs[13] = '{MEM_W_STORE, 32'h7FFFFFFC, 32'h55555555, 32'h0,        1'b0, 8'h00, 1'b0, 1'b0, 32'h0,        1'b0, 1,       4'b0000, 20'h00000, 32'h0,        0};

    rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_op = MEM_NONE; dm_addr = '0; dm_wdata = '0;
    ram_din = '0; uart_tx_busy = 1'b0; uart_rx_valid = 1'b0; uart_rx_data = '0;
    ce_cnt = 0; we_cnt = 0; tx_cnt = 0; tx_cyc = 0;
    repeat (3) step();

    chk("rst_ce_n", 32'(ram_ce_n), 32'd1);
    chk("rst_oe_n", 32'(ram_oe_n), 32'd1);
    chk("rst_we_n", 32'(ram_we_n), 32'd1);
    chk("rst_be_n", 32'(ram_be_n), 32'hF);
    chk("rst_dout_en", 32'(ram_dout_en), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_readies", {30'b0, dm_ready, if_ready}, 32'd0);
    chk("rst_uart", {30'b0, uart_tx_start, uart_rx_ack}, 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 14; i++) begin
      v = vecs[i];
      ram_din = v.din; uart_rx_valid = v.rx_valid; uart_rx_data = v.rx_data; uart_tx_busy = v.busy;
      ce_cnt = 0; we_cnt = 0; tx_cnt = 0;
      dm_op = v.op; dm_addr = v.addr; dm_wdata = v.wdata;
      e = '{rdata: v.exp_rdata, chk_rdata: !is_st(v.op), ack: v.exp_ack, due: cyc + v.lat};
      dm_q.push_back(e);
      wait_done(20);
      step();
      chk($sformatf("v%0d_ce_cycles", i), 32'(ce_cnt), v.ram ? 32'(AC) : 32'd0);
      chk($sformatf("v%0d_we_cycles", i), 32'(we_cnt), (v.ram && is_st(v.op)) ? 32'(AC - 1) : 32'd0);
      chk($sformatf("v%0d_tx_pulses", i), 32'(tx_cnt), 32'(v.exp_tx));
      if (v.ram) begin
        chk($sformatf("v%0d_ram_addr", i), 32'(seen_addr), 32'(v.exp_addr));
        chk($sformatf("v%0d_be_n", i), 32'(seen_be), 32'(v.exp_be));
        chk($sformatf("v%0d_oe_n", i), 32'(seen_oe), 32'(is_st(v.op)));
        if (is_st(v.op)) chk($sformatf("v%0d_dout", i), seen_dout, v.exp_dout);
      end
      if (v.exp_tx != 0) chk($sformatf("v%0d_tx_data", i), 32'(seen_tx), 32'(v.exp_dout[7:0]));
    end

    // Simultaneous data load and fetch: data first, fetch granted after data ready
    ram_din = 32'hCAFEF00D; uart_rx_valid = 1'b0; uart_tx_busy = 1'b0;
    dm_op = MEM_W_LOAD; dm_addr = 32'h80000020; if_req = 1'b1; if_addr = 32'h80000040;
    c0 = cyc;
    e = '{rdata: 32'hCAFEF00D, chk_rdata: 1'b1, ack: 1'b0, due: c0 + 3};
    dm_q.push_back(e);
    e = '{rdata: 32'hCAFEF00D, chk_rdata: 1'b1, ack: 1'b0, due: c0 + 7};
    if_q.push_back(e);
    #1 chk("arb_stall_c0", 32'(stall), 32'd1);
    for (int k = 1; k <= 7; k++) begin
      step();
      chk($sformatf("arb_stall_c%0d", k), 32'(seen_stall), (k < 7) ? 32'd1 : 32'd0);
    end
    wait_done(5);
    step();

    // Fetch from a non-SRAM address completes at once with zero
    if_req = 1'b1; if_addr = 32'hBFD003FC; uart_rx_valid = 1'b1;
    e = '{rdata: 32'h0, chk_rdata: 1'b1, ack: 1'b0, due: cyc + 1};
    if_q.push_back(e);
    wait_done(10);
    step();
    uart_rx_valid = 1'b0;

    // UART store held off by a busy transmitter
    tx_cnt = 0;
    uart_tx_busy = 1'b1;
    dm_op = MEM_B_STORE; dm_addr = 32'hBFD003F8; dm_wdata = 32'h00000041;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("busy_stall_%0d", k), 32'(seen_stall), 32'd1);
    end
    chk("busy_no_tx_start", 32'(tx_cnt), 32'd0);
    uart_tx_busy = 1'b0;
    e = '{rdata: 32'h0, chk_rdata: 1'b0, ack: 1'b0, due: cyc + 2};
    dm_q.push_back(e);
    wait_done(10);
    chk("busy_tx_pulses", 32'(tx_cnt), 32'd1);
    chk("busy_tx_data", 32'(seen_tx), 32'h41);
    chk("busy_tx_cycle", 32'(tx_cyc), 32'(e.due - 1));
    step();

    // Reset in the middle of an SRAM store aborts it without a ready
    dm_op = MEM_W_STORE; dm_addr = 32'h80000100; dm_wdata = 32'h11223344;
    step();
    step();
    chk("abort_we_low_in_access", 32'(ram_we_n), 32'd0);
    rst = 1'b1;
    step();
    chk("abort_we_n", 32'(ram_we_n), 32'd1);
    chk("abort_ce_n", 32'(ram_ce_n), 32'd1);
    chk("abort_be_n", 32'(ram_be_n), 32'hF);
    chk("abort_no_ready", 32'(dm_ready), 32'd0);
    dm_op = MEM_NONE;
    step();
    rst = 1'b0;
    step();
    step();
    chk("abort_still_no_ready", 32'(dm_ready), 32'd0);
    chk("abort_idle_ce_n", 32'(ram_ce_n), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
